// File: rtl/clock_seq_pkg.sv
// Shared state encoding, output widths and helpers for the clock/reset sequencer.
package clock_seq_pkg;

   localparam int unsigned STATE_W    = 3;
   localparam int unsigned LOSS_CNT_W = 8;
   localparam int unsigned RETRY_W    = 4;

   typedef enum logic [STATE_W-1:0] {
      StPllRst   = 3'd0,
      StWaitLock = 3'd1,
      StSettle   = 3'd2,
      StRelSys   = 3'd3,
      StRelAdc   = 3'd4,
      StRelDac   = 3'd5,
      StRun      = 3'd6,
      StFault    = 3'd7
   } state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset value 0.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         q_o    <= 1'b0;
      end else begin
         meta_q <= d_i;
         q_o    <= meta_q;
      end
   end

endmodule

// File: rtl/clock_reset_sequencer.sv
// Brings up the clock wizard, waits for a stable lock, then releases the sys, adc and dac
// reset domains in order; retries on lock timeout and faults when retries run out.
module clock_reset_sequencer
   import clock_seq_pkg::*;
#(
   parameter int unsigned PLL_RESET_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 4096,
   parameter int unsigned SETTLE_CYCLES       = 256,
   parameter int unsigned STAGE_GAP_CYCLES    = 8,
   parameter int unsigned MAX_RETRIES         = 3
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_locked,
   input  logic                  i_relock_req,
   output logic                  o_pll_reset,
   output logic                  o_sys_reset,
   output logic                  o_adc_reset,
   output logic                  o_dac_reset,
   output logic                  o_ready,
   output logic                  o_fault,
   output logic [STATE_W-1:0]    o_state,
   output logic [LOSS_CNT_W-1:0] o_lock_loss_count
);

   localparam int unsigned CNT_MAX = max_u(max_u(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES),
                                           max_u(SETTLE_CYCLES, STAGE_GAP_CYCLES));
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] LOAD_PLL     = CNT_W'(PLL_RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOAD_TIMEOUT = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOAD_GAP     = CNT_W'(STAGE_GAP_CYCLES - 1);
   // The WAIT_LOCK cycle that saw the lock counts as the first stable cycle.
   localparam logic [CNT_W-1:0] LOAD_SETTLE  = CNT_W'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_dec;
   logic [RETRY_W-1:0]      retry_q, retry_d, retry_inc;
   logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
   logic                    locked_s, cnt_zero, lock_lost;
   logic                    pll_d, sys_d, adc_d, dac_d, ready_d, fault_d;
   logic                    pll_q, sys_q, adc_q, dac_q, ready_q, fault_q;

   sync_2ff u_sync_locked (
      .clk_i (i_clock),
      .rst_i (i_reset),
      .d_i   (i_locked),
      .q_o   (locked_s)
   );

   assign cnt_zero  = (cnt_q == '0);
   assign cnt_dec   = cnt_q - CNT_W'(1);
   assign retry_inc = retry_q + RETRY_W'(1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      retry_d   = retry_q;
      loss_d    = loss_q;
      lock_lost = 1'b0;
      unique case (state_q)
         StPllRst: begin
            if (cnt_zero) begin
               state_d = StWaitLock;
               cnt_d   = LOAD_TIMEOUT;
            end else begin
               cnt_d = cnt_dec;
            end
         end
         StWaitLock: begin
            if (locked_s) begin
               state_d = (SETTLE_CYCLES > 1) ? StSettle : StRelSys;
               cnt_d   = (SETTLE_CYCLES > 1) ? LOAD_SETTLE : LOAD_GAP;
            end else if (cnt_zero) begin
               retry_d = retry_inc;
               state_d = (retry_inc == RETRY_W'(MAX_RETRIES)) ? StFault : StPllRst;
               cnt_d   = LOAD_PLL;
            end else begin
               cnt_d = cnt_dec;
            end
         end
         StSettle: begin
            // A dropout only restarts the lock wait; it is not a failed attempt.
            if (!locked_s) begin
               state_d = StWaitLock;
               cnt_d   = LOAD_TIMEOUT;
            end else if (cnt_zero) begin
               state_d = StRelSys;
               cnt_d   = LOAD_GAP;
            end else begin
               cnt_d = cnt_dec;
            end
         end
         StRelSys, StRelAdc, StRelDac: begin
            if (!locked_s) begin
               lock_lost = 1'b1;
            end else if (cnt_zero) begin
               unique case (state_q)
                  StRelSys: state_d = StRelAdc;
                  StRelAdc: state_d = StRelDac;
                  default:  state_d = StRun;
               endcase
               cnt_d = (state_q == StRelDac) ? '0 : LOAD_GAP;
               if (state_q == StRelDac) retry_d = '0;
            end else begin
               cnt_d = cnt_dec;
            end
         end
         StRun: begin
            if (!locked_s) begin
               lock_lost = 1'b1;
            end else if (i_relock_req) begin
               state_d = StPllRst;
               cnt_d   = LOAD_PLL;
            end
         end
         StFault: begin
            if (i_relock_req) begin
               state_d = StPllRst;
               cnt_d   = LOAD_PLL;
               retry_d = '0;
            end
         end
         default: begin
            state_d = StPllRst;
            cnt_d   = LOAD_PLL;
         end
      endcase
      if (lock_lost) begin
         state_d = StPllRst;
         cnt_d   = LOAD_PLL;
         loss_d  = (loss_q == '1) ? loss_q : loss_q + LOSS_CNT_W'(1);
      end
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   assign pll_d   = (state_d == StPllRst) || (state_d == StFault);
   assign sys_d   = !(state_d inside {StRelSys, StRelAdc, StRelDac, StRun});
   assign adc_d   = !(state_d inside {StRelAdc, StRelDac, StRun});
   assign dac_d   = !(state_d inside {StRelDac, StRun});
   assign ready_d = (state_d == StRun);
   assign fault_d = (state_d == StFault);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= StPllRst;
         cnt_q   <= LOAD_PLL;
         retry_q <= '0;
         loss_q  <= '0;
         pll_q   <= 1'b1;
         sys_q   <= 1'b1;
         adc_q   <= 1'b1;
         dac_q   <= 1'b1;
         ready_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         loss_q  <= loss_d;
         pll_q   <= pll_d;
         sys_q   <= sys_d;
         adc_q   <= adc_d;
         dac_q   <= dac_d;
         ready_q <= ready_d;
         fault_q <= fault_d;
      end
   end

   assign o_pll_reset       = pll_q;
   assign o_sys_reset       = sys_q;
   assign o_adc_reset       = adc_q;
   assign o_dac_reset       = dac_q;
   assign o_ready           = ready_q;
   assign o_fault           = fault_q;
   assign o_state           = state_q;
   assign o_lock_loss_count = loss_q;

endmodule
